// File: rtl/seq_det_param.sv
// seq_det_param: serial bit-pattern detector with a run-time reloadable
// pattern and run-time selectable overlapping/non-overlapping detection.
// The input is a valid-qualified bitstream. The outputs are a registered
// one-cycle match pulse and a saturating occurrence counter.
module seq_det_param #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1001,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               pattern_load,
  input  logic [SEQ_LEN-1:0] pattern_in,
  input  logic               overlap_en,
  input  logic               data_valid,
  input  logic               data_in,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  // The fill counter must be able to hold the value SEQ_LEN itself.
  localparam int FILL_W = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN);
  localparam logic [FILL_W-1:0] FILL_HIT = FILL_W'(SEQ_LEN - 1);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [SEQ_LEN-1:0] pat_q,   pat_d;
  logic [SEQ_LEN-1:0] win_q,   win_d;
  logic [FILL_W-1:0]  fill_q,  fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SEQ_LEN-1:0] nwin_s;
  logic               hit_s;

  // Candidate window: the history shifted left, with the incoming bit at the LSB.
  assign nwin_s = {win_q[SEQ_LEN-2:0], data_in};

  // Hit detection. A hit needs a consumed bit, enough earlier eligible bits,
  // and a clear/load-free cycle.
  always_comb begin
    hit_s = 1'b0;
    if (!clear && !pattern_load && data_valid) begin
      hit_s = (fill_q >= FILL_HIT) && (nwin_s == pat_q);
    end else begin
      hit_s = 1'b0;
    end
  end

  // Next-state logic. The priority order is clear, then pattern load, then
  // data consumption.
  always_comb begin
    pat_d   = pat_q;
    win_d   = win_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    count_d = count_q;
    if (clear) begin
      win_d   = '0;
      fill_d  = '0;
      count_d = '0;
    end else if (pattern_load) begin
      pat_d  = pattern_in;
      win_d  = '0;
      fill_d = '0;
    end else if (data_valid) begin
      win_d   = nwin_s;
      match_d = hit_s;
      if (hit_s) begin
        // In overlap mode the matched bits stay eligible for the next match.
        // In non-overlap mode they are all retired.
        fill_d = overlap_en ? FILL_MAX : '0;
        if (count_q != CNT_MAX) begin
          count_d = count_q + CNT_ONE;
        end else begin
          count_d = count_q;
        end
      end else if (fill_q < FILL_MAX) begin
        fill_d = fill_q + FILL_ONE;
      end else begin
        fill_d = fill_q;
      end
    end else begin
      // Idle cycle: a gap in the stream leaves the in-progress sequence intact.
      win_d  = win_q;
      fill_d = fill_q;
    end
  end

  // State and output registers, with an asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q   <= PATTERN;
      win_q   <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      pat_q   <= pat_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      count_q <= count_d;
    end
  end

  assign match       = match_q;
  assign match_count = count_q;

endmodule
